column_feed_ctrl: RTL and testbench
===================================

# column_feed_ctrl

Upstream sequencer for one `column_parallel` bank. It accepts a column of activations over a valid/ready stream and drives `wr_req_p`/`wr_data_p` to fill the bank. It then drives `rd_req_p`/`rd_en` to drain the bank in the order set by `mode`, and flags which downstream `rd_data_p` cycles carry data.

## Interface
- `DATA_WIDTH`, 8, activation word width; matches the bank.
- `COL_DEPTH`, 16, words per column, 2..63.
- `KERNEL`, 3, read group size in mode 1, 1..COL_DEPTH.
- `CNT_WIDTH`, 6, counter width; must satisfy 2^CNT_WIDTH > COL_DEPTH.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous reset, active-low.
- `mode` in 1: 0 = contiguous drain, 1 = grouped drain. Sampled with `start`.
- `start` in 1: one-cycle pulse. Honoured only in IDLE.
- `in_valid` in 1: upstream word valid.
- `in_data` in DATA_WIDTH: upstream word.
- `in_ready` out 1: bank fill window open.
- `dn_stall` in 1: consumer back-pressure; suppresses new reads.
- `wr_req_p` out 1: bank write strobe.
- `wr_data_p` out DATA_WIDTH: bank write data.
- `rd_en` out 1: bank read enable.
- `rd_req_p` out 1: bank read request.
- `out_valid` out 1: high when the bank's `rd_data_p` is valid.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when a column completes.
- `stall_cnt` out 16: saturating count of stalled read cycles (see Configuration).

## Operation
- FSM states are IDLE, FILL, READ and GAP; the encoding is free.
- IDLE to FILL on `start`. `mode` is latched into `mode_q` and both counters are cleared.
- In FILL, `in_ready`=1. Each `in_valid && in_ready` cycle is a handshake that increments `wr_cnt`.
  - FILL goes to READ on the handshake where `wr_cnt` reaches COL_DEPTH-1.
  - `in_ready` drops in the same edge as that transition.
- In READ, a read is issued on every cycle with `!dn_stall` and `rd_cnt < COL_DEPTH`. Each issued read increments `rd_cnt`.
- Mode 0: reads run back to back; only `dn_stall` creates holes.
- Mode 1: after every KERNEL-th issued read (`grp_cnt` wraps), enter GAP for exactly one cycle, then return to READ.
  - No GAP follows the final read, even when that read completes a full group.
  - A short final group (COL_DEPTH mod KERNEL) is legal.
  - GAP lasts one cycle regardless of `dn_stall`.
- When the COL_DEPTH-th read issues, the next state is IDLE and `done` pulses.
- `start` is ignored outside IDLE.
- `in_valid` is ignored outside FILL: no write and no backpressure error.
- Counter arithmetic is unsigned CNT_WIDTH and never wraps in legal configurations.
- `busy`=1 in FILL, READ and GAP.

## Timing
- All outputs are registered. Reset values:
  - `in_ready`, `wr_req_p`, `rd_en`, `rd_req_p`, `out_valid`, `busy` and `done` are 0.
  - `wr_data_p` and `stall_cnt` are 0.
- IDLE with `start` at edge N: `in_ready`=1 and `busy`=1 from N+1.
- Handshake in cycle T: `wr_req_p`=1 and `wr_data_p`=`in_data` in T+1. The write lands in the bank at the end of T+1.
- Last handshake in T:
  - READ holds from T+1.
  - The first `rd_req_p` is no earlier than T+2, so the read never overtakes the last write.
- `rd_en`=1 in every cycle where `rd_req_p`=1, and 0 otherwise.
- `out_valid` equals `rd_req_p` delayed one cycle, matching the bank's one-cycle read flag delay.
- `done` is high in the cycle after the final `rd_req_p`, coincident with the final `out_valid`.
- A new `start` is accepted in the `done` cycle.
- Reset asserted mid-column forces IDLE immediately and clears all counters. A partial column is discarded and the bank has to be reset as well.

## Configuration
- `COLUMN_FEED_STALL_CNT_EN` defined:
  - `stall_cnt` increments in every READ cycle with `dn_stall`=1 and `rd_cnt < COL_DEPTH`.
  - It saturates at 0xFFFF and clears on `start`.
- Not defined: `stall_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Mode 0, COL_DEPTH=16, continuous `in_valid`, data 1..16, no stall:
  - 16 `wr_req_p`, then 16 back-to-back `rd_req_p`.
  - `out_valid` for 16 cycles, `rd_data_p` sequence 1..16.
  - `done` pulse 1 cycle after the last read.
- Mode 1, KERNEL=3:
  - `rd_req_p` pattern 111 0 111 0 111 0 111 0 111 0 1, totalling 21 cycles from first read to last.
  - No gap after the final single read.
- `in_valid` toggled 1010… during FILL:
  - Exactly 16 writes with correct data order.
  - `in_ready` drops after the 16th handshake.
- `dn_stall` held high for 4 cycles mid-READ in mode 0:
  - `rd_req_p` is 0 for those 4 cycles and the read total is still 16.
  - With the macro defined, `stall_cnt`=4; without it, `stall_cnt`=0.
- `start` pulsed during FILL and during READ: ignored, with no restart and no counter change. `start` in the `done` cycle begins a new FILL the next cycle.
- `reset` low for 1 cycle after the 7th write: all outputs 0 and `busy`=0. A following `start` runs a full, clean column.

Source files
------------

// File: rtl/column_feed_if.sv
// Stream and bank-side signals of column_feed_ctrl, grouped so that the
// sequencer, its upstream source and its bank can be wired as one bundle.
interface column_feed_if #(
  parameter int DATA_WIDTH = 8
);
  // Upstream stream: a word moves on every cycle where in_valid && in_ready
  // are both high at the rising edge. The source holds in_data stable while
  // in_valid is high and not yet accepted. in_ready never depends
  // combinationally on in_valid.
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  dn_stall;
  logic                  wr_req_p;
  logic [DATA_WIDTH-1:0] wr_data_p;
  logic                  rd_en;
  logic                  rd_req_p;
  logic                  out_valid;

  modport slave (
    input  in_valid, in_data, dn_stall,
    output in_ready, wr_req_p, wr_data_p, rd_en, rd_req_p, out_valid
  );

  modport master (
    output in_valid, in_data, dn_stall,
    input  in_ready, wr_req_p, wr_data_p, rd_en, rd_req_p, out_valid
  );
endinterface

// File: rtl/column_feed_ctrl.sv
// Fill/drain sequencer for one column_parallel bank: writes a column from a
// valid/ready stream, then reads it back contiguously (mode 0) or in KERNEL
// groups separated by one idle cycle (mode 1). Optional stall counter is
// built when COLUMN_FEED_STALL_CNT_EN is defined.
module column_feed_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int COL_DEPTH  = 16,
  parameter int KERNEL     = 3,
  parameter int CNT_WIDTH  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode,
  input  logic        start,
  column_feed_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_READ = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(COL_DEPTH);
  localparam logic [CNT_WIDTH-1:0] LAST_C  = CNT_WIDTH'(COL_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] KLAST_C = CNT_WIDTH'(KERNEL - 1);

  state_t               state;
  logic                 mode_q;
  logic [CNT_WIDTH-1:0] wr_cnt;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic [CNT_WIDTH-1:0] grp_cnt;
  logic                 last_q;
  logic                 hs;
  logic                 issue;

  assign hs        = bus.in_valid && bus.in_ready;
  assign issue     = (state == S_READ) && !bus.dn_stall && (rd_cnt < DEPTH_C);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      mode_q        <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      grp_cnt       <= '0;
      last_q        <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.wr_req_p  <= 1'b0;
      bus.wr_data_p <= '0;
      bus.rd_en     <= 1'b0;
      bus.rd_req_p  <= 1'b0;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      bus.wr_req_p  <= 1'b0;
      bus.rd_req_p  <= 1'b0;
      bus.rd_en     <= 1'b0;
      // The bank flags read data one cycle after the request; done rides
      // on the same delay so it lines up with the final out_valid.
      bus.out_valid <= bus.rd_req_p;
      done          <= last_q;
      last_q        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_FILL;
            mode_q       <= mode;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            grp_cnt      <= '0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_FILL: begin
          if (hs) begin
            bus.wr_req_p  <= 1'b1;
            bus.wr_data_p <= bus.in_data[DATA_WIDTH-1:0];
            wr_cnt        <= wr_cnt + 1'b1;
            if (wr_cnt == LAST_C) begin
              state        <= S_READ;
              bus.in_ready <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (issue) begin
            bus.rd_req_p <= 1'b1;
            bus.rd_en    <= 1'b1;
            rd_cnt       <= rd_cnt + 1'b1;
            if (rd_cnt == LAST_C) begin
              // No gap after the final read, even on a full group.
              state  <= S_IDLE;
              busy   <= 1'b0;
              last_q <= 1'b1;
            end else if (mode_q) begin
              if (grp_cnt == KLAST_C) begin
                state   <= S_GAP;
                grp_cnt <= '0;
              end else begin
                grp_cnt <= grp_cnt + 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          state <= S_READ;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef COLUMN_FEED_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if ((state == S_IDLE) && start) begin
      stall_q <= '0;
    end else if ((state == S_READ) && bus.dn_stall && (rd_cnt < DEPTH_C) &&
                 (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_column_feed_ctrl.sv
// Self-checking bench for column_feed_ctrl: a column-level reference model
// predicts every output each cycle, and per-column totals pin the model.
module tb_column_feed_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int K     = 3;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        mode  = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;
  logic [1:0]  state_dbg;

  column_feed_if #(.DATA_WIDTH(DW)) bus ();

  column_feed_ctrl #(
    .DATA_WIDTH(DW),
    .COL_DEPTH (DEPTH),
    .KERNEL    (K),
    .CNT_WIDTH (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .stall_cnt(stall_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int tot_wr = 0;
  int rd_cyc_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Column view: a column is active from an accepted start until its last
  // read; words are written until DEPTH have been taken, then DEPTH reads
  // follow, with one idle slot after every K-th read in grouped mode.
  bit m_active, m_mode, m_gap, m_pre;
  int m_writes, m_reads, m_stall;
  bit e_in_ready, e_wr_req, e_rd_req, e_out_valid, e_done, e_busy, e_last;
  bit f_fill, f_read, f_hs, f_issue;

  task automatic compare_outputs();
    chk("in_ready",  bus.in_ready,  e_in_ready);
    chk("wr_req_p",  bus.wr_req_p,  e_wr_req);
    chk("rd_req_p",  bus.rd_req_p,  e_rd_req);
    chk("rd_en",     bus.rd_en,     e_rd_req);
    chk("out_valid", bus.out_valid, e_out_valid);
    chk("done",      done,          e_done);
    chk("busy",      busy,          e_busy);
    chk("stall_cnt", stall_cnt,     m_stall);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      m_active = 0; m_mode = 0; m_gap = 0; m_writes = 0; m_reads = 0; m_stall = 0;
      e_in_ready = 0; e_wr_req = 0; e_rd_req = 0; e_out_valid = 0;
      e_done = 0; e_busy = 0; e_last = 0;
      exp_q.delete();
      compare_outputs();
      chk("rst_wr_data", bus.wr_data_p, 0);
    end else begin
      compare_outputs();
      if (bus.wr_req_p) begin
        tot_wr++;
        chk("wr_data_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("wr_data_p", bus.wr_data_p, exp_q.pop_front());
      end
      if (bus.rd_req_p) rd_cyc_q.push_back(cyc);

      m_pre   = m_active;
      f_fill  = m_active && (m_writes < DEPTH);
      f_read  = m_active && (m_writes == DEPTH) && (m_reads < DEPTH);
      f_hs    = f_fill && bus.in_valid;
      f_issue = f_read && !m_gap && !bus.dn_stall;
`ifdef COLUMN_FEED_STALL_CNT_EN
      if (f_read && !m_gap && bus.dn_stall && m_stall < 65535) m_stall++;
`endif
      e_out_valid = e_rd_req;
      e_done      = e_last;
      e_last      = f_issue && (m_reads == DEPTH - 1);
      e_wr_req    = f_hs;
      e_rd_req    = f_issue;
      if (f_hs) begin
        exp_q.push_back(bus.in_data);
        m_writes++;
      end
      m_gap = f_issue && m_mode && ((m_reads + 1) % K == 0) && (m_reads + 1 < DEPTH);
      if (f_issue) begin
        m_reads++;
        if (m_reads == DEPTH) m_active = 0;
      end
      if (!m_pre && start) begin
        m_active = 1; m_mode = mode; m_gap = 0;
        m_writes = 0; m_reads = 0; m_stall = 0;
      end
      e_in_ready = m_active && (m_writes < DEPTH);
      e_busy     = m_active;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // vkind: 0 continuous valid, 1 toggling 1010, 2 random
  // skind: 0 no stall, 1 one 4-cycle stall after 5 reads, 2 random stall
  task automatic do_column(input bit m, input int vkind, input int skind,
                           input bit noise, input int rst_after,
                           input logic [DW-1:0] dbase,
                           output int nw, output int nr, output int span);
    int base_wr, base_rd, w, stall_left;
    bit hs, stalled, finished;
    base_wr = tot_wr; base_rd = rd_cyc_q.size();
    w = 1; stall_left = 0; stalled = 0; finished = 0;
    mode = m; start = 1'b1;
    step();
    start = 1'b0;
    chk("fill_after_start", bus.in_ready, 1);
    for (int c = 0; c < 400 && !finished; c++) begin
      if (done) begin
        finished = 1;
      end else if (rst_after > 0 && (tot_wr - base_wr) == rst_after) begin
        bus.in_valid = 1'b0;
        bus.dn_stall = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_busy",      busy,          0);
        chk("rst_in_ready",  bus.in_ready,  0);
        chk("rst_wr_req",    bus.wr_req_p,  0);
        chk("rst_rd_req",    bus.rd_req_p,  0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_done",      done,          0);
        step();
        reset = 1'b1;
        finished = 1;
      end else begin
        case (vkind)
          0:       bus.in_valid = 1'b1;
          1:       bus.in_valid = (c % 2 == 0);
          default: bus.in_valid = 1'($urandom_range(0, 1));
        endcase
        bus.in_data = dbase + DW'(w);
        case (skind)
          1: begin
            if (stall_left > 0) begin
              bus.dn_stall = 1'b1;
              stall_left--;
            end else if (!stalled && (rd_cyc_q.size() - base_rd) >= 5) begin
              bus.dn_stall = 1'b1;
              stalled = 1;
              stall_left = 3;
            end else begin
              bus.dn_stall = 1'b0;
            end
          end
          2:       bus.dn_stall = ($urandom_range(0, 3) == 0);
          default: bus.dn_stall = 1'b0;
        endcase
        if (noise && busy && $urandom_range(0, 4) == 0) begin
          start = 1'b1;
          mode  = 1'($urandom_range(0, 1));
        end
        hs = bus.in_valid && bus.in_ready;
        step();
        start = 1'b0;
        if (hs) w++;
      end
    end
    chk("column_finished", finished, 1);
    bus.in_valid = 1'b0;
    bus.dn_stall = 1'b0;
    nw = tot_wr - base_wr;
    nr = rd_cyc_q.size() - base_rd;
    span = (nr > 0) ? (rd_cyc_q[rd_cyc_q.size() - 1] - rd_cyc_q[base_rd] + 1) : 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nw, nr, span;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.dn_stall = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy",      busy,          0);
    chk("init_in_ready",  bus.in_ready,  0);
    chk("init_wr_data",   bus.wr_data_p, 0);
    chk("init_stall_cnt", stall_cnt,     0);
    reset = 1'b1;
    step();
    step();

    // Mode 0, data 1..16, no stall
    do_column(1'b0, 0, 0, 1'b0, 0, 8'h00, nw, nr, span);
    chk("m0_writes", nw, 16);
    chk("m0_reads",  nr, 16);
    chk("m0_span",   span, 16);

    // Mode 1 started in the done cycle: 5 gaps -> 21 cycles
    do_column(1'b1, 0, 0, 1'b0, 0, 8'h40, nw, nr, span);
    chk("m1_reads", nr, 16);
    chk("m1_span",  span, 21);

    // Toggling in_valid
    do_column(1'b0, 1, 0, 1'b0, 0, 8'h80, nw, nr, span);
    chk("tog_writes", nw, 16);
    chk("tog_reads",  nr, 16);

    // 4-cycle stall mid-read in mode 0
    do_column(1'b0, 0, 1, 1'b0, 0, 8'h20, nw, nr, span);
    chk("stall_reads", nr, 16);
    chk("stall_span",  span, 20);
`ifdef COLUMN_FEED_STALL_CNT_EN
    chk("stall_cnt_4", stall_cnt, 4);
`else
    chk("stall_cnt_0", stall_cnt, 0);
`endif

    // Stray start pulses during FILL and READ
    do_column(1'b1, 2, 0, 1'b1, 0, 8'h10, nw, nr, span);
    chk("noise1_writes", nw, 16);
    chk("noise1_reads",  nr, 16);
    do_column(1'b0, 0, 0, 1'b1, 0, 8'h90, nw, nr, span);
    chk("noise0_writes", nw, 16);
    chk("noise0_reads",  nr, 16);

    // Reset after the 7th write, then a clean column
    do_column(1'b0, 0, 0, 1'b0, 7, 8'h30, nw, nr, span);
    step();
    do_column(1'b0, 0, 0, 1'b0, 0, 8'h50, nw, nr, span);
    chk("post_rst_writes", nw, 16);
    chk("post_rst_reads",  nr, 16);
    chk("post_rst_span",   span, 16);

    // Randomized columns
    for (int i = 0; i < 6; i++) begin
      do_column(1'($urandom_range(0, 1)), $urandom_range(0, 2),
                ($urandom_range(0, 1) == 1) ? 2 : 0, 1'($urandom_range(0, 1)),
                0, DW'($urandom_range(0, 255)), nw, nr, span);
      chk("rand_writes", nw, 16);
      chk("rand_reads",  nr, 16);
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
